// File: rtl/nth_root_issue_ctrl.sv
// Issue controller for the nth-root CORDIC core.
// Accepts an IEEE-754 single operand and a root order N. Special operands are
// answered locally. Normal operands are held on the core inputs for the fixed
// core latency, and the core's root is then captured and presented on the output.
module nth_root_issue_ctrl #(
    parameter int unsigned CORE_LAT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [7:0]  in_n,
    output logic [31:0] core_value,
    output logic [7:0]  core_n,
    input  logic [31:0] core_root,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_root,
    output logic [3:0]  out_flags,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(CORE_LAT + 1);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    // Flag encodings: {invalid, inf, zero, bypass}
    localparam logic [3:0] F_INVALID     = 4'b1000;
    localparam logic [3:0] F_INVALID_BYP = 4'b1001;
    localparam logic [3:0] F_ZERO_BYP    = 4'b0011;
    localparam logic [3:0] F_INF_BYP     = 4'b0101;
    localparam logic [3:0] F_BYP         = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       core_value_q, core_value_d;
    logic [7:0]        core_n_q, core_n_d;
    logic [31:0]       out_root_q, out_root_d;
    logic [3:0]        out_flags_q, out_flags_d;

    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_man;
    logic        is_special;
    logic [31:0] spec_root;
    logic [3:0]  spec_flags;

    assign op_sign = in_value[31];
    assign op_exp  = in_value[30:23];
    assign op_man  = in_value[22:0];

    // Special-case classification; the first matching rule wins.
    always_comb begin
        is_special = 1'b1;
        spec_root  = '0;
        spec_flags = '0;
        if (in_n == 8'd0) begin
            spec_root  = QNAN;
            spec_flags = F_INVALID;
        end else if (op_exp == 8'hFF && op_man != 23'd0) begin
            spec_root  = QNAN;
            spec_flags = F_INVALID;
        end else if (op_exp == 8'h00) begin
            // Zeros and denormals (flushed) keep their sign.
            spec_root  = {op_sign, 31'b0};
            spec_flags = F_ZERO_BYP;
        end else if (op_exp == 8'hFF && !op_sign) begin
            spec_root  = POS_INF;
            spec_flags = F_INF_BYP;
        end else if (op_exp == 8'hFF) begin
            spec_root  = in_n[0] ? NEG_INF : QNAN;
            spec_flags = in_n[0] ? F_INF_BYP : F_INVALID_BYP;
        end else if (op_sign && !in_n[0]) begin
            spec_root  = QNAN;
            spec_flags = F_INVALID_BYP;
        end else if (in_n == 8'd1) begin
            spec_root  = in_value;
            spec_flags = F_BYP;
        end else begin
            is_special = 1'b0;
        end
    end

    // Next-state, counter and datapath register updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_value_d = core_value_q;
        core_n_d     = core_n_q;
        out_root_d   = out_root_q;
        out_flags_d  = out_flags_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_special) begin
                        out_root_d  = spec_root;
                        out_flags_d = spec_flags;
                        state_d     = DONE;
                    end else begin
                        core_value_d = in_value;
                        core_n_d     = in_n;
                        cnt_d        = CNT_W'(CORE_LAT);
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_root_d  = core_root;
                    out_flags_d = 4'b0000;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            core_value_q <= '0;
            core_n_q     <= '0;
            out_root_q   <= '0;
            out_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_value_q <= core_value_d;
            core_n_q     <= core_n_d;
            out_root_q   <= out_root_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign core_value = core_value_q;
    assign core_n     = core_n_q;
    assign out_root   = out_root_q;
    assign out_flags  = out_flags_q;

endmodule
